past_history_buf: RTL

//  Synthesizable hardware counterpart of the $past(sig, N, gating) sampled-value function: records a

---
 rtl/past_history_buf.sv | 86 ++++++++
 1 files changed

// File: rtl/past_history_buf.sv
// Gated history recorder for a 1-bit signal and a bus: the hardware analogue of $past(x, N, en).
// Reads are registered and see the history as it stood before the same-edge write.
module past_history_buf #(
  parameter int unsigned B_W   = 4,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned LAG_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a,
  input  logic [B_W-1:0]   b,
  input  logic             rd_req,
  input  logic [LAG_W-1:0] rd_lag,
  output logic             rd_valid,
  output logic             rd_a,
  output logic [B_W-1:0]   rd_b,
  output logic             rd_hit,
  output logic [LAG_W-1:0] count,
  output logic             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SUM_W = LAG_W + 1;
  localparam logic [LAG_W-1:0] DepthL   = LAG_W'(DEPTH);
  localparam logic [SUM_W-1:0] DepthS   = SUM_W'(DEPTH);
  localparam logic [PTR_W-1:0] LastPtr  = PTR_W'(DEPTH - 1);

  logic [B_W:0]       mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [SUM_W-1:0]   rd_sum;
  logic [PTR_W-1:0]   rd_idx;
  logic               hit_d;
  logic [B_W:0]       data_d;

  // (wr_ptr - lag) mod DEPTH without relying on power-of-two wrap; only used when lag <= count
  always_comb begin
    rd_sum = SUM_W'(wr_ptr) + DepthS - SUM_W'(rd_lag);
    if (rd_sum >= DepthS) begin
      rd_sum = rd_sum - DepthS;
    end
    rd_idx = rd_sum[PTR_W-1:0];
    hit_d  = 1'b0;
    data_d = '0;
    if (rd_lag == '0) begin
      hit_d  = 1'b1;
      data_d = {a, b};
    end else if (rd_lag <= count) begin
      hit_d  = 1'b1;
      data_d = mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_a     <= 1'b0;
      rd_b     <= '0;
      rd_hit   <= 1'b0;
    end else begin
      if (en) begin
        wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PTR_W'(1);
        if (count != DepthL) begin
          count <= count + LAG_W'(1);
        end
      end
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_hit       <= hit_d;
        {rd_a, rd_b} <= data_d;
      end
    end
  end

  // Storage is never cleared; count keeps stale entries unreachable after reset.
  always_ff @(posedge clk) begin
    if (rst_n && en) begin
      mem[wr_ptr] <= {a, b};
    end
  end

  assign full = (count == DepthL);

endmodule
